// File: rtl/alu16_seq.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative
// 1-bit-per-cycle SLL/SRA, with a start/busy/done handshake for the control FSM.
module alu16_seq #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       Operacioni,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             Illegal,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_SLT  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1100;
   localparam logic [3:0] OP_SUBI = 4'b1101;

   localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   RES_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shReg_q, shReg_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;
   logic               illegal_q, illegal_d;

   logic [WIDTH-1:0]   aluRes;
   logic               aluOvf;
   logic               isLegal;
   logic               isShift;
   logic [WIDTH-1:0]   shiftNext;

   // Single-cycle datapath, evaluated straight from the live inputs at acceptance.
   always_comb begin
      aluRes  = '0;
      aluOvf  = 1'b0;
      isLegal = 1'b1;
      isShift = 1'b0;
      case (Operacioni)
         OP_AND: aluRes = A & B;
         OP_OR:  aluRes = A | B;
         OP_XOR: aluRes = A ^ B;
         OP_ADD: begin
            aluRes = A + B;
            aluOvf = (A[WIDTH-1] == B[WIDTH-1]) && (aluRes[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB, OP_SUBI: begin
            aluRes = A - B;
            aluOvf = (A[WIDTH-1] != B[WIDTH-1]) && (aluRes[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT: aluRes = ($signed(A) < $signed(B)) ? RES_ONE : '0;
         OP_SLL, OP_SRA: isShift = 1'b1;
         default: isLegal = 1'b0;
      endcase
   end

   assign shiftNext = left_q ? {shReg_q[WIDTH-2:0], 1'b0}
                             : {shReg_q[WIDTH-1], shReg_q[WIDTH-1:1]};

   // Result and flags only change on a completion edge, so a shift in flight
   // leaves the previous op's outputs visible until it finishes.
   always_comb begin
      state_d   = state_q;
      shReg_d   = shReg_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      result_d  = result_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (!isLegal) begin
                  result_d  = '0;
                  zero_d    = 1'b1;
                  ovf_d     = 1'b0;
                  illegal_d = 1'b1;
                  state_d   = DONE;
               end else if (isShift) begin
                  shReg_d = A;
                  cnt_d   = B[SHAMT_W-1:0];
                  left_d  = (Operacioni == OP_SLL);
                  if (B[SHAMT_W-1:0] == '0) begin
                     result_d  = A;
                     zero_d    = (A == '0);
                     ovf_d     = 1'b0;
                     illegal_d = 1'b0;
                     state_d   = DONE;
                  end else begin
                     state_d = SHIFT;
                  end
               end else begin
                  result_d  = aluRes;
                  zero_d    = (aluRes == '0);
                  ovf_d     = aluOvf;
                  illegal_d = 1'b0;
                  state_d   = DONE;
               end
            end
         end
         SHIFT: begin
            shReg_d = shiftNext;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               result_d  = shiftNext;
               zero_d    = (shiftNext == '0);
               ovf_d     = 1'b0;
               illegal_d = 1'b0;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shReg_q   <= '0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shReg_q   <= shReg_d;
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
      end
   end

   assign Result   = result_q;
   assign Zero     = zero_q;
   assign Overflow = ovf_q;
   assign Illegal  = illegal_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_alu16_seq.sv
// Directed self-checking bench for alu16_seq: hand-computed vectors covering
// reset abort, flags, signed compare, iterative shifts, handshake and illegal codes.
module tb_alu16_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  Operacioni;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Result;
   logic        Zero;
   logic        Overflow;
   logic        Illegal;
   logic        busy;
   logic        done;

   int nChecks = 0;
   int nErrors = 0;
   int lat;

   alu16_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .Operacioni (Operacioni),
      .A          (A),
      .B          (B),
      .Result     (Result),
      .Zero       (Zero),
      .Overflow   (Overflow),
      .Illegal    (Illegal),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nChecks++;
      assert (obs === exp)
      else begin
         nErrors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launches one op and returns the number of negedges until done is seen.
   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, output int latency);
      @(negedge clk);
      Operacioni = op;
      A          = a;
      B          = b;
      start      = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      latency = 1;
      while (!done && latency < 40) begin
         @(negedge clk);
         latency++;
      end
   endtask

   task automatic checkAll(input string tag, input logic [15:0] res, input logic z,
                           input logic o, input logic ill, input int expLat);
      checkOutput({tag, "_lat"}, 16'(lat), 16'(expLat));
      checkOutput({tag, "_done"}, {15'd0, done}, 16'd1);
      checkOutput({tag, "_res"}, Result, res);
      checkOutput({tag, "_zero"}, {15'd0, Zero}, {15'd0, z});
      checkOutput({tag, "_ovf"}, {15'd0, Overflow}, {15'd0, o});
      checkOutput({tag, "_ill"}, {15'd0, Illegal}, {15'd0, ill});
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      Operacioni = 4'b0000;
      A          = 16'h0000;
      B          = 16'h0000;
      $display("[TB] starting alu16_seq directed test");

      @(negedge clk);
      checkOutput("rst_res", Result, 16'h0000);
      checkOutput("rst_zero", {15'd0, Zero}, 16'd0);
      checkOutput("rst_ovf", {15'd0, Overflow}, 16'd0);
      checkOutput("rst_ill", {15'd0, Illegal}, 16'd0);
      checkOutput("rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("rst_done", {15'd0, done}, 16'd0);
      reset = 1'b0;

      // Reset in the middle of a long shift must abort it
      @(negedge clk);
      Operacioni = 4'b0110;
      A          = 16'h0001;
      B          = 16'h000F;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("abort_busy_before", {15'd0, busy}, 16'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_res", Result, 16'h0000);
      checkOutput("abort_busy", {15'd0, busy}, 16'd0);
      checkOutput("abort_done", {15'd0, done}, 16'd0);
      checkOutput("abort_zero", {15'd0, Zero}, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle", {15'd0, busy}, 16'd0);

      applyStimulus(4'b0100, 16'h0003, 16'h0004, lat);
      checkAll("add_3_4", 16'h0007, 1'b0, 1'b0, 1'b0, 1);

      applyStimulus(4'b0100, 16'h7FFF, 16'h0001, lat);
      checkAll("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1);

      applyStimulus(4'b1100, 16'h1234, 16'h1234, lat);
      checkAll("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b0, 1);

      applyStimulus(4'b1101, 16'h8000, 16'h0001, lat);
      checkAll("subi_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b0, 1);

      applyStimulus(4'b1100, 16'h7FFF, 16'hFFFF, lat);
      checkAll("sub_ovf_pos", 16'h8000, 1'b0, 1'b1, 1'b0, 1);

      applyStimulus(4'b0001, 16'hFFFF, 16'h0001, lat);
      checkAll("slt_neg_lt", 16'h0001, 1'b0, 1'b0, 1'b0, 1);

      applyStimulus(4'b0001, 16'h0001, 16'hFFFF, lat);
      checkAll("slt_pos_ge", 16'h0000, 1'b1, 1'b0, 1'b0, 1);

      applyStimulus(4'b0111, 16'h8000, 16'h0003, lat);
      checkAll("sra_3", 16'hF000, 1'b0, 1'b0, 1'b0, 4);

      applyStimulus(4'b0111, 16'h4000, 16'h0002, lat);
      checkAll("sra_pos", 16'h1000, 1'b0, 1'b0, 1'b0, 3);

      applyStimulus(4'b0110, 16'h0001, 16'h000F, lat);
      checkAll("sll_15", 16'h8000, 1'b0, 1'b0, 1'b0, 16);

      // Only B[3:0] is the shift amount, so B=0x0010 is a zero shift
      applyStimulus(4'b0110, 16'hABCD, 16'h0010, lat);
      checkAll("sll_0", 16'hABCD, 1'b0, 1'b0, 1'b0, 1);

      // A second start while shifting is ignored and never queued
      @(negedge clk);
      Operacioni = 4'b0110;
      A          = 16'h0003;
      B          = 16'h0005;
      start      = 1'b1;
      @(negedge clk);
      Operacioni = 4'b0100;
      A          = 16'h0001;
      B          = 16'h0001;
      checkOutput("mid_busy", {15'd0, busy}, 16'd1);
      checkOutput("mid_hold_res", Result, 16'hABCD);
      @(negedge clk);
      start = 1'b0;
      lat   = 2;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkAll("mid_sll_5", 16'h0060, 1'b0, 1'b0, 1'b0, 6);
      @(negedge clk);
      checkOutput("mid_no_queue_busy", {15'd0, busy}, 16'd0);
      checkOutput("mid_no_queue_done", {15'd0, done}, 16'd0);
      checkOutput("mid_hold_after", Result, 16'h0060);

      applyStimulus(4'b0101, 16'h1234, 16'h5678, lat);
      checkAll("illegal", 16'h0000, 1'b1, 1'b0, 1'b1, 1);

      applyStimulus(4'b0000, 16'h0F0F, 16'h00FF, lat);
      checkAll("and_clr_ill", 16'h000F, 1'b0, 1'b0, 1'b0, 1);

      // Back-to-back single-cycle ops: done is a one-cycle pulse
      applyStimulus(4'b0010, 16'h00F0, 16'h0F00, lat);
      checkAll("or", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(4'b0011, 16'hFFFF, 16'h00FF, lat);
      checkAll("xor", 16'hFF00, 1'b0, 1'b0, 1'b0, 1);
      @(negedge clk);
      checkOutput("pulse_done_low", {15'd0, done}, 16'd0);
      checkOutput("pulse_idle", {15'd0, busy}, 16'd0);
      checkOutput("pulse_hold", Result, 16'hFF00);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- 16-bit execute-stage ALU that sits directly downstream of the ALU control unit.
- Consumes the 4-bit Operacioni code plus two operands, and returns a registered Result with Zero/Overflow flags.
- Logic and arithmetic ops complete in one cycle; SLL/SRA use an iterative 1-bit-per-cycle shifter.
- A start/busy/done handshake lets the multicycle control FSM stall while the shift runs.

Parameters:
- WIDTH, 16, operand/result width.
- SHAMT_W, 4, shift-amount width; equals log2(WIDTH), and B[SHAMT_W-1:0] is the shift amount.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- Operacioni  input  4  operation code from the ALU control unit.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt or immediate); B[3:0] is the shift amount.
- Result  output  WIDTH  registered result; holds until the next accepted op.
- Zero  output  1  registered, equals (Result == 0); used for BEQ.
- Overflow  output  1  signed overflow; valid for ADD/SUB codes only, 0 otherwise.
- Illegal  output  1  set when the accepted code is unsupported.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse: Result and flags are final.

Behaviour:
- Reset (async, active-high): state=IDLE; Result=0, Zero=0, Overflow=0, Illegal=0, busy=0, done=0. Reset mid-operation aborts the op with no partial result kept.
- States: IDLE, SHIFT, DONE. Encoding is free; busy = (state != IDLE).
- Acceptance: start=1 in IDLE at edge k latches Operacioni, A and B. start in SHIFT or DONE is ignored and not queued.
- Single-cycle codes, computed at edge k, then IDLE->DONE (done high for the cycle after edge k):
  - 0000 AND: A&B
  - 0010 OR: A|B
  - 0011 XOR: A^B
  - 0100 ADD: A+B, mod 2^16
  - 1100 SUB and 1101 SUBI: A-B, mod 2^16
  - 0001 SLT: 16'h0001 if $signed(A) < $signed(B), else 0
- Overflow rules:
  - ADD: A[15]==B[15] && R[15]!=A[15].
  - SUB/SUBI: A[15]!=B[15] && R[15]!=A[15].
  - All other codes: Overflow=0.
- Shift codes: 0110 SLL (logical left, zero fill) and 0111 SRA (arithmetic right, sign fill).
  - Edge k: shift register <= A, counter <= B[3:0].
  - If counter==0: go to DONE with Result=A (latency 1).
  - Else: go to SHIFT. Each edge in SHIFT shifts 1 bit and decrements the counter. When the counter reaches 0, load Result and go to DONE.
  - done is high in the cycle after edge k+n for n=B[3:0]≥1, i.e. latency n+1 cycles, worst case 16.
- Any other code: Result=0, Zero=1, Overflow=0, Illegal=1, done after 1 cycle. Illegal clears on the next accepted legal op.
- DONE lasts exactly one cycle, then returns to IDLE. A new start is accepted from the first IDLE cycle onward, so back-to-back single-cycle ops complete one every 2 cycles.
- Result and flags are stable from the done cycle until the next accepted start's completion edge. Intermediate shift values are never visible on Result.
- Operand/opcode changes after acceptance have no effect on the op in flight.

Test Plan:
- Reset mid-op and reset values: assert reset during SLL with B=15 → all outputs 0 immediately, state IDLE. Then ADD 3+4 → Result=0x0007.
- ADD overflow: Operacioni=0100, A=0x7FFF, B=0x0001, start → next cycle done=1, Result=0x8000, Overflow=1, Zero=0.
- SUB and BEQ flag: Operacioni=1100, A=0x1234, B=0x1234 → Result=0x0000, Zero=1, Overflow=0.
  - Then 1101, A=0x8000, B=0x0001 → Result=0x7FFF, Overflow=1.
- SLT signed: A=0xFFFF, B=0x0001 → Result=0x0001. A=0x0001, B=0xFFFF → Result=0x0000.
- Shifts:
  - SRA A=0x8000, B=0x0003 → busy high 4 cycles, done 4 cycles after start, Result=0xF000.
  - SLL A=0x0001, B=0x000F → Result=0x8000 at 16 cycles.
  - SLL with B=0 → Result=A after 1 cycle.
- Handshake and illegal code: pulse start again mid-shift with different operands → ignored, original result delivered.
  - Operacioni=0101 → Result=0, Zero=1, Illegal=1.
  - A following legal AND (0x0F0F & 0x00FF) → Result=0x000F, Illegal=0.
